// File: rtl/mul16_seq.sv
// mul16_seq: sequential 16x16 shift-and-add multiplier with a start/busy/done
// handshake. One multiplier bit is retired per cycle, so the product is ready
// 16 cycles after the request is accepted, whatever the operand values.
//
// Optional feature macro: MUL16_SIGNED_EN
//   defined   -> signed_op selects a two's-complement multiply (sign/magnitude
//                capture plus a final negation of the magnitude product).
//   undefined -> signed_op is ignored; every operation is unsigned.
//
// The registered product halves feed the writeback select mux directly, so
// they only change on the final iteration edge and otherwise hold.
module mul16_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        signed_op,
    output logic        busy,
    output logic        done,
    output logic [15:0] prod_hi,
    output logic [15:0] prod_lo,
    output logic        prod_ovf
);

    localparam int DATA_W = 16;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state;
    logic [PROD_W-1:0]   mcand;     // zero-extended multiplicand magnitude
    logic [DATA_W-1:0]   mplier;    // multiplier, shifted right each iteration
    logic [PROD_W-1:0]   acc;       // partial-product accumulator
    logic [3:0]          cnt;       // iteration index, 0..15

    logic                accept;
    logic [DATA_W-1:0]   cap_a;
    logic [DATA_W-1:0]   cap_b;
    logic [PROD_W-1:0]   addend;
    logic [PROD_W-1:0]   acc_nxt;
    logic [PROD_W-1:0]   res;
    logic                ovf_nxt;

    // Overflow rule: the product must be representable in 16 bits, either as
    // an unsigned value or as a sign-extended two's-complement value.
    function automatic logic ovf_chk(input logic [PROD_W-1:0] p,
                                     input logic              is_signed);
        if (is_signed)
            return p[PROD_W-1:DATA_W] != {DATA_W{p[DATA_W-1]}};
        else
            return p[PROD_W-1:DATA_W] != '0;
    endfunction

`ifdef MUL16_SIGNED_EN
    // Magnitude of a two's-complement operand. -32768 maps to 0x8000, which
    // is then used as the unsigned value 32768.
    function automatic logic [DATA_W-1:0] mag16(input logic signed [DATA_W-1:0] v);
        logic signed [DATA_W-1:0] n;
        n = -v;
        return v[DATA_W-1] ? $unsigned(n) : $unsigned(v);
    endfunction

    // Two's-complement negation of the full-width magnitude product.
    function automatic logic [PROD_W-1:0] neg32(input logic [PROD_W-1:0] v);
        return ~v + {{(PROD_W-1){1'b0}}, 1'b1};
    endfunction

    logic neg;   // result must be negated at the end
    logic sop;   // operation in flight is a signed multiply

    // Latch the result sign and the operating mode on the accepting edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            neg <= 1'b0;
            sop <= 1'b0;
        end else if (accept) begin
            neg <= signed_op & (a[DATA_W-1] ^ b[DATA_W-1]);
            sop <= signed_op;
        end
    end
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op;
`endif

    // A request is taken whenever no iteration is in progress, including the
    // DONE cycle, which allows back-to-back operation.
    assign accept = (state != ST_RUN) && start;

    // Operand capture values and the per-iteration accumulate/finish datapath.
    always_comb begin
`ifdef MUL16_SIGNED_EN
        cap_a = signed_op ? mag16(a) : a;
        cap_b = signed_op ? mag16(b) : b;
`else
        cap_a = a;
        cap_b = b;
`endif
        addend  = mplier[0] ? (mcand << cnt) : '0;
        acc_nxt = acc + addend;
`ifdef MUL16_SIGNED_EN
        res     = neg ? neg32(acc_nxt) : acc_nxt;
        ovf_nxt = ovf_chk(res, sop);
`else
        res     = acc_nxt;
        ovf_nxt = ovf_chk(res, 1'b0);
`endif
    end

    // Control FSM with registered handshake outputs and the iteration datapath.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            prod_hi  <= '0;
            prod_lo  <= '0;
            prod_ovf <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state  <= ST_RUN;
                        busy   <= 1'b1;
                        mcand  <= {{DATA_W{1'b0}}, cap_a};
                        mplier <= cap_b;
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        prod_hi  <= res[PROD_W-1:DATA_W];
                        prod_lo  <= res[DATA_W-1:0];
                        prod_ovf <= ovf_nxt;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq: self-checking bench for mul16_seq. A behavioural model
// computes each product with plain integer arithmetic and releases it after
// the fixed latency; a compare process checks every output on every cycle,
// and directed cases pin the model with hand-computed literal results.
module tb_mul16_seq;

`ifdef MUL16_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        signed_op = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] prod_hi;
    logic [15:0] prod_lo;
    logic        prod_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    mul16_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .signed_op (signed_op),
        .busy      (busy),
        .done      (done),
        .prod_hi   (prod_hi),
        .prod_lo   (prod_lo),
        .prod_ovf  (prod_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y,
                                             input logic s);
        longint sx, sy, p;
        sx = longint'(x);
        sy = longint'(y);
        if (s && SIGNED_EN) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end
        p = sx * sy;
        return p[31:0];
    endfunction

    // Overflow: the true product lies outside the 16-bit range of its mode.
    function automatic logic ref_ovf(input logic [31:0] p, input logic s);
        int sp;
        sp = $signed(p);
        if (s)
            return (sp > 32767) || (sp < -32768);
        else
            return p > 32'h0000_FFFF;
    endfunction

    // Behavioural model: a request is taken when not busy; its product is
    // published exactly 16 edges later together with a one-cycle done.
    logic        m_busy, m_done, m_ovf, p_sgn;
    logic [31:0] m_prod, p_prod;
    int          m_rem;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_ovf  <= 1'b0;
            m_rem  <= 0;
            p_prod <= '0;
            p_sgn  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy && start) begin
                m_busy <= 1'b1;
                m_rem  <= 16;
                p_prod <= ref_prod(a, b, signed_op);
                p_sgn  <= signed_op && SIGNED_EN;
            end else if (m_busy) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_prod <= p_prod;
                    m_ovf  <= ref_ovf(p_prod, p_sgn);
                end
            end
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'b0, busy}, {31'b0, m_busy});
            check("done", {31'b0, done}, {31'b0, m_done});
            check("prod", {prod_hi, prod_lo}, m_prod);
            check("prod_ovf", {31'b0, prod_ovf}, {31'b0, m_ovf});
            check("busy_and_done", {31'b0, busy & done}, 32'd0);
        end
    end

    // Drive a request at the current negedge and drop start one cycle later.
    task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic s);
        a = x;
        b = y;
        signed_op = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting busy cycles seen on the way.
    task automatic wait_done(output int bcnt, output bit ok);
        bcnt = 0;
        ok   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                return;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_done: no done within 40 cycles, got busy=%0b, expected done=1", busy);
    endtask

    task automatic op_check(input string name, input logic [15:0] x, input logic [15:0] y,
                            input logic s, input logic [31:0] exp_p, input logic exp_ovf);
        int bcnt;
        bit ok;
        @(negedge clk);
        issue(x, y, s);
        wait_done(bcnt, ok);
        if (ok) begin
            check({name, "_latency"}, bcnt, 32'd16);
            check({name, "_prod"}, {prod_hi, prod_lo}, exp_p);
            check({name, "_ovf"}, {31'b0, prod_ovf}, {31'b0, exp_ovf});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int bcnt;
        bit ok;
        logic [15:0] rx, ry;
        logic        rs;

        // Reset, then idle with start low: all outputs must stay zero.
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en  = 1'b1;
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_outputs", {busy, done, prod_ovf, prod_hi[12:0], prod_lo}, 32'd0);

        // Basic unsigned multiply with latency check.
        op_check("u3x5", 16'h0003, 16'h0005, 1'b0, 32'h0000_000F, 1'b0);
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);

        // Largest unsigned product; a start pulse mid-run must be ignored.
        @(negedge clk);
        issue(16'hFFFF, 16'hFFFF, 1'b0);
        repeat (4) @(negedge clk);
        a = 16'h0001;
        b = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bcnt, ok);
        if (ok) begin
            check("uffff_prod", {prod_hi, prod_lo}, 32'hFFFE_0001);
            check("uffff_ovf", {31'b0, prod_ovf}, 32'd1);
        end
        @(negedge clk);
        check("uffff_no_restart", {31'b0, busy}, 32'd0);

        if (SIGNED_EN) begin
            op_check("s_m3x7", 16'hFFFD, 16'h0007, 1'b1, 32'hFFFF_FFEB, 1'b0);
            op_check("s_min2", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 1'b1);
        end else begin
            // signed_op must be ignored: 0xFFFD * 7 as unsigned.
            op_check("nosign_m3x7", 16'hFFFD, 16'h0007, 1'b1, 32'h0006_FFEB, 1'b1);
        end

        // Back-to-back: new request during the DONE cycle of the previous one.
        @(negedge clk);
        issue(16'd2, 16'd3, 1'b0);
        wait_done(bcnt, ok);
        check("b2b_first", {prod_hi, prod_lo}, 32'h0000_0006);
        issue(16'd4, 16'd5, 1'b0);
        check("b2b_busy_again", {31'b0, busy}, 32'd1);
        bcnt = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            check("b2b_hold", {prod_hi, prod_lo}, 32'h0000_0006);
            bcnt++;
            @(negedge clk);
        end
        check("b2b_hold_cycles", bcnt, 32'd16);
        check("b2b_second", {prod_hi, prod_lo}, 32'h0000_0014);
        check("b2b_second_done", {31'b0, done}, 32'd1);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        issue(16'h1234, 16'h0010, 1'b0);
        repeat (7) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("areset_prod", {prod_hi, prod_lo}, 32'd0);
        check("areset_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) bcnt++;
            @(negedge clk);
        end
        check("areset_no_done", bcnt, 32'd0);
        op_check("after_reset_1x1", 16'd1, 16'd1, 1'b0, 32'h0000_0001, 1'b0);

        // Randomized operations, mixed gaps and back-to-back requests.
        for (int n = 0; n < 40; n++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: rx = 16'h0000;
                1: ry = 16'h8000;
                2: rx = 16'hFFFF;
                default: ;
            endcase
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            issue(rx, ry, rs);
            wait_done(bcnt, ok);
            if (ok) check("rand_latency", bcnt, 32'd16);
        end
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul16_seq.md
# mul16_seq

Sequential 16x16 multiplier for the 16-bit datapath, sitting directly upstream of the 8-way writeback select mux. Its registered product halves drive two of that mux's inputs; which one reaches the register file is chosen there. It uses a start/busy/done handshake and computes one multiplier bit per cycle, so no wide combinational array sits in the critical path.

## Interface
Parameters: none.

Clock and reset:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.

Inputs:
- start  in  1  request; sampled only while not busy.
- a  in  16  multiplicand; captured on the accepting edge.
- b  in  16  multiplier; captured on the accepting edge.
- signed_op  in  1  two's-complement mode when high; honoured only with MUL16_SIGNED_EN.

Outputs:
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result is valid from this cycle on.
- prod_hi  out  16  product bits [31:16]; feeds writeback mux input.
- prod_lo  out  16  product bits [15:0]; feeds writeback mux input.
- prod_ovf  out  1  product does not fit in 16 bits.

## Operation
- States:
  - IDLE: no operation, result held.
  - RUN: iterating.
  - DONE: one cycle, result fresh.
- State transitions:
  - IDLE or DONE + start -> RUN.
  - DONE without start -> IDLE.
  - RUN, count 15 -> DONE.
- Accepting edge:
  - Capture a and b, or their magnitudes in signed mode.
  - Record sign = a[15]^b[15] in signed mode.
  - Clear the 32-bit accumulator and the 4-bit count.
- Each RUN cycle:
  - If the current multiplier LSB is 1, add the multiplicand, shifted left by count, into the accumulator.
  - Shift the multiplier right by 1 and increment the count.
- Final RUN edge writes the completed accumulator into {prod_hi, prod_lo}. In signed mode with sign=1 it writes the two's-complement negation.
- prod_hi, prod_lo and prod_ovf hold their value until the next final RUN edge. A new start does not clear them early.
- prod_ovf:
  - Unsigned: prod_hi != 0.
  - Signed: prod_hi != {16{prod_lo[15]}}.
- Arithmetic is full 32-bit with no truncation. The magnitude of -32768 is 0x8000, treated as unsigned 32768.
- start while in RUN is ignored; no queueing, and operands are not re-sampled.

## Timing
- Reset values: state IDLE, busy=0, done=0, prod_hi=0, prod_lo=0, prod_ovf=0, count=0.
- Reset asserted mid-operation aborts immediately to reset values. No done pulse is issued.
- Latency: start sampled at edge E0.
  - busy=1 after E0 through E16.
  - Edges E1..E16 are the 16 iterations.
  - After E16: busy=0, done=1, result valid.
  - After E17: done=0 unless done was re-armed by a later operation.
- Latency is fixed at 16 cycles from acceptance to done, regardless of operand values, including zero.
- Back-to-back: start high during the DONE cycle is accepted at E17. busy returns to 1 after E17, and the old result stays on the outputs until the new final edge.
- busy and done are never high in the same cycle.

## Configuration
- MUL16_SIGNED_EN defined:
  - signed_op selects two's-complement multiply.
  - Sign and magnitude logic and the final negation are present.
- MUL16_SIGNED_EN undefined:
  - signed_op is ignored and every operation is unsigned.
  - prod_ovf uses the unsigned rule.
  - No negation logic is synthesised.

## Test plan
- Reset then idle 5 cycles, start=0:
  - All outputs remain 0.
- a=0x0003, b=0x0005, unsigned, start at E0:
  - busy for 16 cycles.
  - done only in the cycle after E16.
  - prod_hi=0x0000, prod_lo=0x000F, prod_ovf=0.
- a=0xFFFF, b=0xFFFF, unsigned:
  - prod_hi=0xFFFE, prod_lo=0x0001, prod_ovf=1.
  - start pulsed at E5 during RUN has no effect.
- With MUL16_SIGNED_EN, signed_op=1:
  - a=0xFFFD (-3), b=0x0007: prod_hi=0xFFFF, prod_lo=0xFFEB (-21), prod_ovf=0.
  - a=0x8000, b=0x8000: prod_hi=0x4000, prod_lo=0x0000, prod_ovf=1.
- Back-to-back: first op 2*3, start held during its DONE cycle with a=4, b=5.
  - First result 0x00000006 holds for 16 cycles.
  - Then 0x00000014 appears with done.
- Reset asserted at E8 of 0x1234*0x0010:
  - Outputs drop to 0 asynchronously.
  - No done pulse afterwards.
  - The next op 1*1 gives prod_lo=0x0001.
